// File: rtl/romulus_config_pkg.sv
// Shared configuration for the Romulus TBC sequencer.
// Round/slot geometry and sequencer state encoding.
package romulus_config_pkg;

    localparam int ROUNDS       = 40;
    localparam int CLKS_PER_RND = 4;
    localparam int CONSTW       = 6;
    localparam int RNDW         = 6;
    localparam int SLOTW        =
        (CLKS_PER_RND > 1) ? $clog2(CLKS_PER_RND) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CORR0,
        CORR1,
        DONE
    } state_t;

endpackage

// File: rtl/skinny_rc_lfsr.sv
// SKINNY round-constant LFSR.
// Clear has priority over step.
import romulus_config_pkg::*;

module skinny_rc_lfsr (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    output logic [CONSTW-1:0] rc
);

    logic fb;

    assign fb = rc[CONSTW-1] ^ rc[CONSTW-2] ^ 1'b1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rc <= '0;
        end else if (step) begin
            rc <= {rc[CONSTW-2:0], fb};
        end
    end

endmodule

// File: rtl/romulus_tbc_ctrl.sv
// Sequencer for one masked SKINNY-128-384+ TBC call.
// Runs the round/slot schedule, then the two-cycle tweakey correction.
import romulus_config_pkg::*;

module romulus_tbc_ctrl (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    inc_cnt_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CLKS_PER_RND-1:0] ring_en,
    output logic [CONSTW-1:0]       constant,
    output logic                    senc,
    output logic                    sen,
    output logic                    xenc,
    output logic                    xen,
    output logic                    yenc,
    output logic                    yen,
    output logic                    zenc,
    output logic                    zen,
    output logic [1:0]              share_en,
    output logic                    correct_cnt
);

    state_t            state;
    state_t            state_n;
    logic [SLOTW-1:0]  slot;
    logic [RNDW-1:0]   rnd;
    logic              inc_cnt_q;
    logic              last_slot;
    logic              last_rnd;
    logic              accept;
    logic              rc_step;
    logic              rc_clear;

    assign last_slot = (slot == SLOTW'(CLKS_PER_RND - 1));
    assign last_rnd  = (rnd == RNDW'(ROUNDS - 1));
    assign accept    = (state == IDLE) && start_i;
    assign rc_step   = accept || ((state == RUN) && last_slot);
    assign rc_clear  = (state == DONE);

    skinny_rc_lfsr u_rc (
        .clk   (clk),
        .rst   (rst),
        .clear (rc_clear),
        .step  (rc_step),
        .rc    (constant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= '0;
            rnd       <= '0;
            inc_cnt_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == RUN) begin
                slot <= last_slot ? '0 : slot + SLOTW'(1);
                if (last_slot) begin
                    rnd <= rnd + RNDW'(1);
                end
            end else begin
                slot <= '0;
                if (state == IDLE) begin
                    rnd <= '0;
                end
            end
            if (accept) begin
                inc_cnt_q <= inc_cnt_i;
            end
        end
    end

    always_comb begin
        state_n     = state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        ring_en     = '0;
        senc        = 1'b0;
        sen         = 1'b0;
        xenc        = 1'b0;
        xen         = 1'b0;
        yenc        = 1'b0;
        yen         = 1'b0;
        zenc        = 1'b0;
        zen         = 1'b0;
        share_en    = 2'b00;
        correct_cnt = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                busy_o  = 1'b1;
                ring_en = CLKS_PER_RND'(1) << slot;
                senc    = 1'b1;
                sen     = 1'b1;
                xenc    = 1'b1;
                xen     = 1'b1;
                yenc    = 1'b1;
                yen     = 1'b1;
                zenc    = 1'b1;
                zen     = 1'b1;
                if (last_slot && last_rnd) begin
                    state_n = CORR0;
                end
            end
            CORR0: begin
                busy_o      = 1'b1;
                xen         = 1'b1;
                yen         = 1'b1;
                zen         = 1'b1;
                share_en    = 2'b01;
                correct_cnt = inc_cnt_q;
                state_n     = CORR1;
            end
            CORR1: begin
                busy_o   = 1'b1;
                xen      = 1'b1;
                share_en = 2'b10;
                state_n  = DONE;
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
